// File: rtl/l2_sqrt_iter_if.sv
// Handshake bundle between the sum-of-squares accumulator and the square-root stage.
// master: the upstream producer of operands and consumer of results.
// slave:  the square-root block itself.
interface l2_sqrt_iter_if #(
  parameter int unsigned IN_W = 20
);
  localparam int unsigned OUT_W = IN_W / 2;

  logic             valid_in;
  logic [IN_W-1:0]  sq_in;
  logic             ready_in;
  logic [OUT_W-1:0] f;
  logic [OUT_W:0]   rem;
  logic             valid_out;

  modport master (
    output valid_in,
    output sq_in,
    input  ready_in,
    input  f,
    input  rem,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  sq_in,
    output ready_in,
    output f,
    output rem,
    output valid_out
  );
endinterface

// File: rtl/l2_sqrt_iter.sv
// Final stage of the L2-norm datapath: integer square root of the accumulated sum of
// squares, computed with a restoring digit-by-digit algorithm at one root bit per clock.
// Optional macro L2_SQRT_ROUND_EN rounds the reported root to nearest (saturating);
// the remainder is always relative to the floor root.
module l2_sqrt_iter #(
  parameter int unsigned IN_W = 20
) (
  input logic           clk,
  input logic           reset,
  l2_sqrt_iter_if.slave bus
);

  localparam int unsigned OUT_W = IN_W / 2;
  // Internal remainder / trial width: one guard bit above the worst-case remainder.
  localparam int unsigned RW    = OUT_W + 2;
  localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  op_q, op_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [RW-1:0]    prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] f_q, f_d;
  logic [OUT_W:0]   rem_q, rem_d;
  logic             valid_q, valid_d;

  logic [RW-1:0]    rem_t;
  logic [RW-1:0]    trial;
  logic [RW-1:0]    diff;
  logic             take;
  logic [OUT_W-1:0] root_final;

  // One restoring step: bring down the next two operand bits and try to subtract {root,01}.
  // The partial remainder never exceeds 2*root, so dropping its top bits on the shift is
  // lossless.
  always_comb begin
    rem_t = RW'({prem_q, op_q[IN_W-1 -: 2]});
    trial = {root_q, 2'b01};
    diff  = rem_t - trial;
    take  = (rem_t >= trial);
  end

`ifdef L2_SQRT_ROUND_EN
  // Round to nearest: sqrt(x) >= r + 0.5 exactly when the floor remainder exceeds r.
  always_comb begin
    root_final = root_q;
    if ((prem_q > RW'(root_q)) && (root_q != {OUT_W{1'b1}})) begin
      root_final = root_q + OUT_W'(1);
    end
  end
`else
  assign root_final = root_q;
`endif

  // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    root_d  = root_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    rem_d   = rem_q;
    valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          op_d    = bus.sq_in;
          root_d  = '0;
          prem_d  = '0;
          cnt_d   = CW'(OUT_W - 1);
          state_d = StCalc;
        end
      end

      StCalc: begin
        prem_d = take ? diff : rem_t;
        root_d = {root_q[OUT_W-2:0], take};
        op_d   = op_q << 2;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      StDone: begin
        f_d     = root_final;
        rem_d   = prem_q[OUT_W:0];
        valid_d = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      root_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      root_q  <= root_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_in  = (state_q == StIdle);
  assign bus.f         = f_q;
  assign bus.rem       = rem_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_l2_sqrt_iter.sv
// Scoreboard bench for l2_sqrt_iter: expected root/remainder/latency queued on accept,
// compared when valid_out pulses.
module tb_l2_sqrt_iter;

  localparam int unsigned IN_W  = 20;
  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned LAT   = OUT_W + 1;

  typedef struct {
    int unsigned f;
    int unsigned rem;
    int unsigned acc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_sent   = 0;
  logic        prev_vo  = 1'b0;
  exp_t        sb[$];
  int unsigned pulses[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  l2_sqrt_iter_if #(.IN_W(IN_W)) bus ();

  l2_sqrt_iter #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: brute-force floor root, optional round-to-nearest with saturation.
  function automatic exp_t model(input int unsigned x, input int unsigned acc);
    exp_t e;
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    e.rem = x - r * r;
    e.f   = r;
`ifdef L2_SQRT_ROUND_EN
    if (e.rem > r && r < (1 << OUT_W) - 1) e.f = r + 1;
`endif
    e.acc = acc;
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every valid_out pulse.
  always @(negedge clk) begin
    if (!reset && bus.valid_out) begin
      pulses.push_back(cyc);
      check_eq("pulse_width", {31'd0, prev_vo}, 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_out", {31'd0, bus.valid_out}, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("f", 32'(bus.f), mon_e.f);
        check_eq("rem", 32'(bus.rem), mon_e.rem);
        check_eq("latency", cyc - mon_e.acc, LAT);
      end
    end
    prev_vo <= bus.valid_out;
  end

  task automatic send(input int unsigned x);
    int n = 0;
    @(negedge clk);
    while (!bus.ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", {31'd0, bus.ready_in}, 1);
    if (!bus.ready_in) return;
    bus.valid_in = 1'b1;
    bus.sq_in    = IN_W'(x);
    @(posedge clk);
    #1;
    sb.push_back(model(x, cyc));
    n_sent++;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ps;
    bus.valid_in = 1'b0;
    bus.sq_in    = '0;

    // Reset state while reset is held.
    #2;
    check_eq("rst_valid_out", {31'd0, bus.valid_out}, 0);
    check_eq("rst_f", 32'(bus.f), 0);
    check_eq("rst_rem", 32'(bus.rem), 0);
    check_eq("rst_ready", {31'd0, bus.ready_in}, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Zero operand and ready returning alongside the pulse.
    send(0);
    wait_drain();
    check_eq("ready_after_done", {31'd0, bus.ready_in}, 1);

    // Back-to-back operands: 12-cycle spacing between pulses.
    send(16);
    send(17);
    wait_drain();
    ps = pulses.size();
    if (ps >= 2) check_eq("pulse_spacing", pulses[ps-1] - pulses[ps-2], OUT_W + 2);
    else check_eq("pulse_count", ps, 2);

    // Boundaries and rounding cases.
    send(1048575);
    send(20);
    send(21);
    send(1);
    send(2);
    send(3);
    wait_drain();

    // A handful of random operands.
    for (int i = 0; i < 6; i++) send($urandom_range(0, (1 << IN_W) - 1));
    wait_drain();

    // Offers while busy are ignored.
    send(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("busy_ready", {31'd0, bus.ready_in}, 0);
      bus.valid_in = 1'b1;
      bus.sq_in    = IN_W'(9);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    check_eq("no_extra_pulse", pulses.size(), n_sent);
    check_eq("busy_f_held", 32'(bus.f), 10);

    // Asynchronous reset in the middle of a calculation.
    send(400);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_valid_out", {31'd0, bus.valid_out}, 0);
    check_eq("abort_f", 32'(bus.f), 0);
    check_eq("abort_rem", 32'(bus.rem), 0);
    check_eq("abort_ready", {31'd0, bus.ready_in}, 1);
    sb.delete();
    n_sent--;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort_no_pulse", pulses.size(), n_sent);
    send(400);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
